// File: rtl/brlwe_frame_rx.sv
// -----------------------------------------------------------------------------
// brlwe_frame_rx
//
// Receive-side frame deserializer for the BRLWE datapath. It captures one
// N-coefficient frame from the bit-serial key stream (m_in) and the two
// byte-serial ciphertext streams (c1_in, c2_in) while `load` is high. It holds
// the frame for the ring-LWE core, which reads it through a registered
// random-access port. It checks the framing (exact window length, early or
// late `load` deassertion, re-load while holding) and reports the outcome.
//
// Ports
//   clk            system clock, rising edge
//   resetn         asynchronous active-low reset
//   load           frame window, high for exactly N cycles per frame
//   m_in           key/message bit k, valid on the k-th load-high cycle
//   c1_in, c2_in   ciphertext coefficient k, aligned with m_in
//   rd_en          read request from the core
//   rd_addr        coefficient index to read
//   rd_m           stored bit at rd_addr (registered)
//   rd_c1, rd_c2   stored coefficients at rd_addr (registered)
//   rd_valid       read data valid, one cycle after rd_en
//   frame_release  core has consumed the held frame. This is the "release"
//                  strobe of the top level; `release` is a reserved word in
//                  SystemVerilog, so the port carries this name instead.
//   busy           receiving (state RECV), registered
//   ready          a complete, error-free frame is held (state HOLD), registered
//   frame_done     single-cycle pulse on good frame completion
//   frame_err      sticky framing error, cleared at the next frame start
//   rx_count       samples accepted in the current or last frame (saturates at N)
//   state_dbg      current FSM state: 0 IDLE, 1 RECV, 2 HOLD, 3 DRAIN
//
// Read port handshake: there is no backpressure. A request is taken in every
// cycle where rd_en=1. In the next cycle rd_valid=1 and rd_m/rd_c1/rd_c2 hold
// the entry that was addressed. When rd_en=0, rd_valid drops and the rd_*
// data holds its previous value. One read is accepted per cycle.
// -----------------------------------------------------------------------------
module brlwe_frame_rx #(
  parameter int N  = 256,
  parameter int CW = 8,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          load,
  input  logic          m_in,
  input  logic [CW-1:0] c1_in,
  input  logic [CW-1:0] c2_in,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic          rd_m,
  output logic [CW-1:0] rd_c1,
  output logic [CW-1:0] rd_c2,
  output logic          rd_valid,
  input  logic          frame_release,
  output logic          busy,
  output logic          ready,
  output logic          frame_done,
  output logic          frame_err,
  output logic [AW:0]   rx_count,
  output logic [1:0]    state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam int          DW    = 2 * CW + 1;
  localparam logic [AW:0] FULL  = (AW + 1)'(N);
  localparam logic [AW:0] ONE   = (AW + 1)'(1);

  state_t state;

  // Frame storage, one {m, c1, c2} word per coefficient. It is not reset:
  // a frame is only meaningful after it has been written completely.
  logic [DW-1:0] mem [N];

  logic          wr_en;
  logic [AW-1:0] wr_addr;

  assign state_dbg = state;

  // Write side. A frame start (from IDLE or HOLD) always writes index 0.
  // Inside the frame the write index is the running count. Once the count
  // reaches N the sample is an overrun and is not stored, so index 0 keeps
  // sample 0.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = '0;
    case (state)
      IDLE, HOLD: wr_en = load;
      RECV: begin
        wr_en   = load && (rx_count != FULL);
        wr_addr = rx_count[AW-1:0];
      end
      default: wr_en = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= {m_in, c1_in, c2_in};
    end
  end

  // Read side. The memory read uses the pre-edge contents, so a read and a
  // write to the same index in one cycle return the old word.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_valid <= 1'b0;
      rd_m     <= 1'b0;
      rd_c1    <= '0;
      rd_c2    <= '0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        {rd_m, rd_c1, rd_c2} <= mem[rd_addr];
      end
    end
  end

  // Framing FSM. busy/ready are driven alongside each state change so that
  // they always match the registered state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      rx_count   <= '0;
      busy       <= 1'b0;
      ready      <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            state     <= RECV;
            rx_count  <= ONE;
            frame_err <= 1'b0;
            busy      <= 1'b1;
          end
        end

        RECV: begin
          if (load) begin
            if (rx_count == FULL) begin
              // Window longer than N: drop the rest of it in DRAIN.
              state     <= DRAIN;
              frame_err <= 1'b1;
              busy      <= 1'b0;
            end else begin
              rx_count <= rx_count + ONE;
            end
          end else if (rx_count == FULL) begin
            state      <= HOLD;
            busy       <= 1'b0;
            ready      <= 1'b1;
            frame_done <= 1'b1;
          end else begin
            // Window shorter than N: abandon the partial frame.
            state     <= IDLE;
            frame_err <= 1'b1;
            busy      <= 1'b0;
          end
        end

        HOLD: begin
          // A new window takes priority over a simultaneous release.
          if (load) begin
            state     <= RECV;
            rx_count  <= ONE;
            frame_err <= 1'b0;
            busy      <= 1'b1;
            ready     <= 1'b0;
          end else if (frame_release) begin
            state <= IDLE;
            ready <= 1'b0;
          end
        end

        DRAIN: begin
          if (!load) begin
            state <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_brlwe_frame_rx.sv
// -----------------------------------------------------------------------------
// tb_brlwe_frame_rx
//
// Self-checking bench for brlwe_frame_rx. Inputs change on the falling edge
// and outputs are sampled on the falling edge before the inputs change.
// Expected read words are queued when a read is issued and compared when
// rd_valid comes back.
// -----------------------------------------------------------------------------
module tb_brlwe_frame_rx;

  localparam int N  = 256;
  localparam int CW = 8;
  localparam int AW = 8;
  localparam int DW = 2 * CW + 1;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- DUT
  logic          load;
  logic          m_in;
  logic [CW-1:0] c1_in;
  logic [CW-1:0] c2_in;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic          rd_m;
  logic [CW-1:0] rd_c1;
  logic [CW-1:0] rd_c2;
  logic          rd_valid;
  logic          frame_release;
  logic          busy;
  logic          ready;
  logic          frame_done;
  logic          frame_err;
  logic [AW:0]   rx_count;
  logic [1:0]    state_dbg;

  brlwe_frame_rx #(.N(N), .CW(CW), .AW(AW)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .load          (load),
    .m_in          (m_in),
    .c1_in         (c1_in),
    .c2_in         (c2_in),
    .rd_en         (rd_en),
    .rd_addr       (rd_addr),
    .rd_m          (rd_m),
    .rd_c1         (rd_c1),
    .rd_c2         (rd_c2),
    .rd_valid      (rd_valid),
    .frame_release (frame_release),
    .busy          (busy),
    .ready         (ready),
    .frame_done    (frame_done),
    .frame_err     (frame_err),
    .rx_count      (rx_count),
    .state_dbg     (state_dbg)
  );

  // ---------------------------------------------------------------- scoreboard
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] ref_mem [N];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc_cnt  = 0;
  int fd_cnt   = 0;
  int fd_cycle = -1;

  logic busy_k1, ready_k1, err_k1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // One clock: wait for the falling edge, then retire any returned read.
  task automatic cyc();
    logic [DW-1:0] e;
    @(negedge clk);
    cyc_cnt++;
    if (frame_done) begin
      fd_cnt++;
      fd_cycle = cyc_cnt;
    end
    if (rd_valid) begin
      if (exp_q.size() == 0) begin
        check("rd_spurious", 32'(rd_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("rd_data", 32'({rd_m, rd_c1, rd_c2}), 32'(e));
      end
    end
  endtask

  // ---------------------------------------------------------------- drivers
  // kind 0: m=k[0], c1=k, c2=255-k; kind 1: c1=A5, random m/c2;
  // kind 2: random m/c2, c1 chosen so that sample 256 differs from sample 0.
  function automatic logic [DW-1:0] sample(input int k, input int kind);
    logic [7:0] kb;
    logic [7:0] c1v;
    kb = k[7:0];
    case (kind)
      0: return {kb[0], kb, 8'd255 - kb};
      1: return {1'($urandom_range(0, 1)), 8'hA5, 8'($urandom_range(0, 255))};
      default: begin
        c1v = 8'(k + k / 256);
        return {1'($urandom_range(0, 1)), c1v, 8'($urandom_range(0, 255))};
      end
    endcase
  endfunction

  // Leaves `load` high after the last sample; the caller drops it.
  task automatic send_frame(input int len, input int kind, input bit rel_first);
    logic [DW-1:0] s;
    for (int k = 0; k < len; k++) begin
      s = sample(k, kind);
      load = 1'b1;
      {m_in, c1_in, c2_in} = s;
      frame_release = (k == 0) ? rel_first : 1'b0;
      if (k < N) ref_mem[k] = s;
      cyc();
      if (k == 0) begin
        busy_k1  = busy;
        ready_k1 = ready;
        err_k1   = frame_err;
      end
    end
    frame_release = 1'b0;
  endtask

  task automatic read_all();
    for (int a = 0; a < N; a++) begin
      rd_en   = 1'b1;
      rd_addr = AW'(a);
      exp_q.push_back(ref_mem[a]);
      cyc();
    end
    rd_en = 1'b0;
    cyc();
    check("rd_queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic read_one(input int a);
    rd_en   = 1'b1;
    rd_addr = AW'(a);
    exp_q.push_back(ref_mem[a]);
    cyc();
    rd_en = 1'b0;
    cyc();
    check("rd_one_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // Full good frame plus end-of-frame checks.
  task automatic good_frame(input string tag, input int kind, input bit rel_first);
    int start;
    int fd_before;
    fd_before = fd_cnt;
    start = cyc_cnt;
    send_frame(N, kind, rel_first);
    check({tag, "_busy_c1"}, 32'(busy_k1), 32'd1);
    check({tag, "_ready_c1"}, 32'(ready_k1), 32'd0);
    check({tag, "_err_c1"}, 32'(err_k1), 32'd0);
    load = 1'b0;
    cyc();
    check({tag, "_done"}, 32'(frame_done), 32'd1);
    check({tag, "_done_cycle"}, 32'(fd_cycle - start), 32'(N + 1));
    check({tag, "_ready"}, 32'(ready), 32'd1);
    check({tag, "_busy_off"}, 32'(busy), 32'd0);
    check({tag, "_count"}, 32'(rx_count), 32'(N));
    check({tag, "_err"}, 32'(frame_err), 32'd0);
    check({tag, "_state"}, 32'(state_dbg), 32'd2);
    cyc();
    check({tag, "_done_low"}, 32'(frame_done), 32'd0);
    check({tag, "_done_once"}, 32'(fd_cnt - fd_before), 32'd1);
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    int fd_before;
    resetn = 1'b0;
    load = 1'b0; m_in = 1'b0; c1_in = '0; c2_in = '0;
    rd_en = 1'b0; rd_addr = '0; frame_release = 1'b0;

    // Reset state
    cyc();
    cyc();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_count", 32'(rx_count), 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    resetn = 1'b1;
    cyc();

    // Good frame and full readback
    good_frame("good", 0, 1'b0);
    read_all();

    // Release: ready drops next cycle, held data still readable
    frame_release = 1'b1;
    cyc();
    frame_release = 1'b0;
    check("rel_ready", 32'(ready), 32'd0);
    check("rel_state", 32'(state_dbg), 32'd0);
    rd_en = 1'b1;
    rd_addr = AW'(5);
    exp_q.push_back(ref_mem[5]);
    cyc();
    rd_en = 1'b0;
    check("rel_rd_valid", 32'(rd_valid), 32'd1);
    cyc();
    check("rel_queue", 32'(exp_q.size()), 32'd0);

    // Underrun: 100 samples
    fd_before = fd_cnt;
    send_frame(100, 0, 1'b0);
    load = 1'b0;
    cyc();
    check("under_err", 32'(frame_err), 32'd1);
    check("under_count", 32'(rx_count), 32'd100);
    check("under_ready", 32'(ready), 32'd0);
    check("under_state", 32'(state_dbg), 32'd0);
    check("under_busy", 32'(busy), 32'd0);
    check("under_no_done", 32'(fd_cnt - fd_before), 32'd0);

    // Overrun: 260 samples; sample 256 must not land at index 0
    fd_before = fd_cnt;
    send_frame(260, 2, 1'b0);
    check("over_drain", 32'(state_dbg), 32'd3);
    load = 1'b0;
    cyc();
    check("over_err", 32'(frame_err), 32'd1);
    check("over_ready", 32'(ready), 32'd0);
    check("over_state", 32'(state_dbg), 32'd0);
    check("over_count", 32'(rx_count), 32'(N));
    check("over_no_done", 32'(fd_cnt - fd_before), 32'd0);
    read_one(0);

    // Good frame clears the sticky error, then re-load in HOLD with release
    good_frame("clr", 0, 1'b0);
    good_frame("reload", 1, 1'b1);
    read_all();

    // Reset mid-frame at sample 128
    send_frame(128, 0, 1'b0);
    resetn = 1'b0;
    #1;
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_ready", 32'(ready), 32'd0);
    check("mid_done", 32'(frame_done), 32'd0);
    check("mid_err", 32'(frame_err), 32'd0);
    check("mid_rd_valid", 32'(rd_valid), 32'd0);
    check("mid_rd_data", 32'({rd_m, rd_c1, rd_c2}), 32'd0);
    check("mid_count", 32'(rx_count), 32'd0);
    check("mid_state", 32'(state_dbg), 32'd0);
    load = 1'b0;
    cyc();
    cyc();
    resetn = 1'b1;
    cyc();
    good_frame("post_rst", 0, 1'b0);
    read_all();

    check("final_queue", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/brlwe_frame_rx.md
# brlwe_frame_rx

Receive-side frame deserializer for the BRLWE datapath. It accepts the bit-serial key stream and the two byte-serial ciphertext streams that the SAKURA-G top level drives under a `load` window. It buffers one complete N-coefficient frame and then presents it to the ring-LWE core through a random-access read port. It also checks the framing: exact window length, early or late `load` deassertion, and re-load while holding. It reports frame completion and errors back to the top level.

## Interface
- `N`, 256, coefficients per frame; load window length in cycles
- `CW`, 8, width of each c1/c2 coefficient
- `AW`, 8, address width; must satisfy 2^AW = N
- `clk`  in  1  system clock; all logic on the rising edge
- `resetn`  in  1  asynchronous active-low reset
- `load`  in  1  frame window; high for exactly N consecutive cycles per frame
- `m_in`  in  1  key/message bit k, valid on the k-th cycle of `load` high
- `c1_in`  in  CW  c1 coefficient k, aligned with `m_in`
- `c2_in`  in  CW  c2 coefficient k, aligned with `m_in`
- `rd_en`  in  1  read request from the core
- `rd_addr`  in  AW  coefficient index to read
- `rd_m`  out  1  stored bit at `rd_addr`
- `rd_c1`  out  CW  stored c1 at `rd_addr`
- `rd_c2`  out  CW  stored c2 at `rd_addr`
- `rd_valid`  out  1  read data valid, one cycle after `rd_en`
- `release`  in  1  core has consumed the held frame
- `busy`  out  1  receiving (state RECV)
- `ready`  out  1  a complete, error-free frame is held
- `frame_done`  out  1  single-cycle pulse on good frame completion
- `frame_err`  out  1  sticky framing error; cleared at the next frame start
- `rx_count`  out  AW+1  samples accepted in the current or last frame

## Operation
- Storage: N-entry array of {m, c1, c2} (1+2·CW bits); write port from the stream, read port from `rd_addr`. Contents are not reset.
- States: IDLE, RECV, HOLD, DRAIN. `busy` = (state==RECV); `ready` = (state==HOLD). Both are registered.
- IDLE:
  - `load`=1 → RECV. Write the sample at index 0, `rx_count`←1, `frame_err`←0.
- RECV, `load`=1:
  - If `rx_count` < N: write the sample at index `rx_count`, then increment `rx_count`.
  - If `rx_count` == N: overrun. Discard the sample, set `frame_err`←1, go to DRAIN.
- RECV, `load`=0:
  - If `rx_count` == N: go to HOLD and pulse `frame_done`.
  - Otherwise (underrun): set `frame_err`←1 and go to IDLE.
- DRAIN:
  - Discard all samples while `load`=1.
  - On `load`=0, go to IDLE. `rx_count` stays at N.
- HOLD:
  - `release`=1 → IDLE.
  - `load`=1 → RECV. This is a new frame: index 0 is written, `rx_count`←1, `frame_err`←0.
  - `load` and `release` in the same cycle: `load` wins.
- Read port:
  - Registered. `rd_en` in cycle t gives `rd_*` and `rd_valid`=1 in cycle t+1.
  - `rd_*` holds its last value when `rd_en`=0.
  - Reads are legal in any state but are meaningful only while `ready`=1.
  - A read and a write to the same index in one cycle returns the old data.
- Index arithmetic:
  - The write index is `rx_count[AW-1:0]`.
  - `rx_count` saturates at N and never wraps.
- Reset (`resetn`=0, any time, including mid-frame):
  - Immediately: state IDLE, `rx_count`=0.
  - All outputs 0: `busy`, `ready`, `frame_done`, `frame_err`, `rd_valid`, `rd_m`, `rd_c1`, `rd_c2`.
  - A partial frame is abandoned. The first `load`=1 after reset release starts a fresh frame.

## Timing
- Sample k is captured on the rising edge at the end of the k-th `load`-high cycle (k = 0..N-1). Stream data must be registered with `load` (same-cycle alignment).
- Good frame, with the first `load` high in cycle 0:
  - Last sample in cycle N-1; `load` low in cycle N.
  - `ready`=1 and `frame_done`=1 from cycle N+1.
  - `frame_done` is low again in cycle N+2.
- Frame start: `busy` rises the cycle after the first `load`=1 and falls the cycle after `load`=0.
- `release` sampled in cycle t → `ready`=0 in cycle t+1.
- Back-to-back frames need no gap: `load` may re-assert in the first HOLD cycle.
- Read latency is 1 cycle, with one read accepted per cycle.

## Test plan
- Good frame: N=256 samples with m=k[0], c1=k, c2=255-k, then read all addresses. Required: `frame_done` pulses once in cycle 257; `rx_count`=256; `ready`=1; for every k, rd_m = k[0], rd_c1 = k and rd_c2 = 255-k, each one cycle after its read.
- Underrun: `load` high for 100 cycles. Required: `frame_err`=1, `rx_count`=100, `ready`=0, no `frame_done`, state IDLE.
- Overrun: `load` high for 260 cycles. Required: `frame_err`=1, `ready`=0, and a readback of index 0 returns sample 0, not sample 256.
- Re-load in HOLD: after a good frame, assert `load` and `release` in the same cycle with new data c1=0xA5. Required: `ready` drops, `frame_err`=0, and after 256 cycles the readback gives c1=0xA5 everywhere.
- Reset mid-frame: assert `resetn`=0 at sample 128. Required: all outputs are 0 immediately. A following full frame completes normally with `rx_count`=256.
- Release: in HOLD, pulse `release` for one cycle. Required: `ready`=0 on the next cycle, and a `rd_en` still returns the held data with `rd_valid`=1.
